// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : memory pipeline stage between execute and writeback.
//
// Accepts one instruction at a time from execute. Pass-through ops reach the
// writeback port one cycle later. Loads and stores issue one doubleword
// request on the dmem port, wait for its response and then present the
// result (aligned and extended load data, or nothing for stores).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   execute -> memory handshake
//   in_instruction      ALU opcode code (loads 59..65, stores 43..46)
//   in_result           ALU result or effective address
//   in_store_data       rs2 value for stores
//   in_rd               destination register
//   dmem_req_*          doubleword-aligned request with byte strobes
//   dmem_resp_*         read data / store ack
//   out_*               writeback handshake and payload
//   misalign_fault      misaligned access report (trap build only)
//
// Configuration
//   MEM_STAGE_MISALIGN_TRAP_EN  defined: misaligned accesses skip memory and
//                               raise misalign_fault in the OUT cycles.
//                               undefined: low address bits are forced to
//                               size alignment and misalign_fault is 0.
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_instruction,
    input  logic [63:0] in_result,
    input  logic [63:0] in_store_data,
    input  logic [4:0]  in_rd,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [63:0] dmem_req_addr,
    output logic        dmem_req_write,
    output logic [63:0] dmem_req_wdata,
    output logic [7:0]  dmem_req_wstrb,
    input  logic        dmem_resp_valid,
    input  logic [63:0] dmem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [63:0] out_data,
    output logic        out_wb_en,
    output logic        misalign_fault
);

    localparam int unsigned XLEN   = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned OFF_W  = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [7:0] OP_SB  = 8'd43;
    localparam logic [7:0] OP_SH  = 8'd44;
    localparam logic [7:0] OP_SW  = 8'd45;
    localparam logic [7:0] OP_SD  = 8'd46;
    localparam logic [7:0] OP_LB  = 8'd59;
    localparam logic [7:0] OP_LH  = 8'd60;
    localparam logic [7:0] OP_LW  = 8'd61;
    localparam logic [7:0] OP_LBU = 8'd62;
    localparam logic [7:0] OP_LHU = 8'd63;
    localparam logic [7:0] OP_LWU = 8'd64;
    localparam logic [7:0] OP_LD  = 8'd65;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // FSM and transaction context
    logic [1:0]        state_q,     state_d;
    logic [OFF_W-1:0]  off_q,       off_d;
    logic [1:0]        size_q,      size_d;
    logic              sgn_q,       sgn_d;
    logic              load_q,      load_d;
    logic [RD_W-1:0]   rd_q,        rd_d;

    // registered outputs
    logic              in_ready_q,  in_ready_d;
    logic              req_valid_q, req_valid_d;
    logic [XLEN-1:0]   req_addr_q,  req_addr_d;
    logic              req_write_q, req_write_d;
    logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
    logic [STRB_W-1:0] req_wstrb_q, req_wstrb_d;
    logic              out_valid_q, out_valid_d;
    logic [RD_W-1:0]   out_rd_q,    out_rd_d;
    logic [XLEN-1:0]   out_data_q,  out_data_d;
    logic              out_wb_en_q, out_wb_en_d;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic              fault_q,     fault_d;
`endif

    // decode of the incoming instruction
    logic              dec_load;
    logic              dec_store;
    logic [1:0]        dec_size;
    logic              dec_signed;
    logic [OFF_W-1:0]  align_mask;
    logic [OFF_W-1:0]  dec_off;
    logic [STRB_W-1:0] dec_strb_base;
    logic              dec_misaligned;

    // load data path
    logic [XLEN-1:0]   resp_shifted;
    logic [XLEN-1:0]   load_value;

    // Truncate the lane-aligned response to the access size and extend it.
    function automatic logic [63:0] load_extend(input logic [63:0] raw,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic [63:0] res;
        case (size)
            SZ_B:    res = sgn ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
            SZ_H:    res = sgn ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
            SZ_W:    res = sgn ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Opcode decode: class, access size, signedness.
    always_comb begin
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_size   = SZ_B;
        dec_signed = 1'b0;
        case (in_instruction)
            OP_LB:  begin dec_load  = 1'b1; dec_size = SZ_B; dec_signed = 1'b1; end
            OP_LH:  begin dec_load  = 1'b1; dec_size = SZ_H; dec_signed = 1'b1; end
            OP_LW:  begin dec_load  = 1'b1; dec_size = SZ_W; dec_signed = 1'b1; end
            OP_LD:  begin dec_load  = 1'b1; dec_size = SZ_D; dec_signed = 1'b1; end
            OP_LBU: begin dec_load  = 1'b1; dec_size = SZ_B; end
            OP_LHU: begin dec_load  = 1'b1; dec_size = SZ_H; end
            OP_LWU: begin dec_load  = 1'b1; dec_size = SZ_W; end
            OP_SB:  begin dec_store = 1'b1; dec_size = SZ_B; end
            OP_SH:  begin dec_store = 1'b1; dec_size = SZ_H; end
            OP_SW:  begin dec_store = 1'b1; dec_size = SZ_W; end
            OP_SD:  begin dec_store = 1'b1; dec_size = SZ_D; end
            default: ;
        endcase
    end

    // Byte-offset alignment mask and base strobe per access size.
    always_comb begin
        align_mask    = 3'b000;
        dec_strb_base = 8'hFF;
        case (dec_size)
            SZ_B:    begin align_mask = 3'b111; dec_strb_base = 8'h01; end
            SZ_H:    begin align_mask = 3'b110; dec_strb_base = 8'h03; end
            SZ_W:    begin align_mask = 3'b100; dec_strb_base = 8'h0F; end
            default: begin align_mask = 3'b000; dec_strb_base = 8'hFF; end
        endcase
    end

    // Aligned accesses are unaffected by the mask; misaligned ones either
    // trap (before reaching here) or get their low bits forced down.
    assign dec_off = in_result[2:0] & align_mask;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign dec_misaligned = (dec_load || dec_store) &&
                            ((in_result[2:0] & ~align_mask) != 3'b000);
`else
    assign dec_misaligned = 1'b0;
`endif

    // Move the addressed bytes of the doubleword down to bit 0.
    assign resp_shifted = dmem_resp_data >> {off_q, 3'b000};
    assign load_value   = load_extend(resp_shifted, size_q, sgn_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        load_d      = load_q;
        rd_d        = rd_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_write_d = req_write_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        out_valid_d = out_valid_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        out_wb_en_d = out_wb_en_q;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        fault_d     = fault_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if ((dec_load || dec_store) && !dec_misaligned) begin
                        state_d     = S_REQ;
                        off_d       = dec_off;
                        size_d      = dec_size;
                        sgn_d       = dec_signed;
                        load_d      = dec_load;
                        rd_d        = in_rd;
                        req_valid_d = 1'b1;
                        req_addr_d  = {in_result[63:3], 3'b000};
                        req_write_d = dec_store;
                        req_wdata_d = dec_store ? (in_store_data << {dec_off, 3'b000})
                                                : {XLEN{1'b0}};
                        req_wstrb_d = dec_store ? STRB_W'(dec_strb_base << dec_off)
                                                : {STRB_W{1'b0}};
                    end else if (dec_misaligned) begin
                        state_d     = S_OUT;
                        out_valid_d = 1'b1;
                        out_rd_d    = in_rd;
                        out_data_d  = {XLEN{1'b0}};
                        out_wb_en_d = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                        fault_d     = 1'b1;
`endif
                    end else begin
                        state_d     = S_OUT;
                        out_valid_d = 1'b1;
                        out_rd_d    = in_rd;
                        out_data_d  = in_result;
                        out_wb_en_d = (in_rd != 5'd0);
                    end
                end
            end

            S_REQ: begin
                if (dmem_req_ready) begin
                    state_d     = S_WAIT;
                    req_valid_d = 1'b0;
                end
            end

            S_WAIT: begin
                if (dmem_resp_valid) begin
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    out_rd_d    = rd_q;
                    out_data_d  = load_q ? load_value : {XLEN{1'b0}};
                    out_wb_en_d = load_q && (rd_q != 5'd0);
                end
            end

            S_OUT: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_wb_en_d = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                    fault_d     = 1'b0;
`endif
                end
            end

            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            off_q       <= '0;
            size_q      <= SZ_B;
            sgn_q       <= 1'b0;
            load_q      <= 1'b0;
            rd_q        <= '0;
            in_ready_q  <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_write_q <= 1'b0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            out_wb_en_q <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            load_q      <= load_d;
            rd_q        <= rd_d;
            in_ready_q  <= in_ready_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_write_q <= req_write_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            out_wb_en_q <= out_wb_en_d;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign in_ready       = in_ready_q;
    assign dmem_req_valid = req_valid_q;
    assign dmem_req_addr  = req_addr_q;
    assign dmem_req_write = req_write_q;
    assign dmem_req_wdata = req_wdata_q;
    assign dmem_req_wstrb = req_wstrb_q;
    assign out_valid      = out_valid_q;
    assign out_rd         = out_rd_q;
    assign out_data       = out_data_q;
    assign out_wb_en      = out_wb_en_q;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign misalign_fault = fault_q;
`else
    assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage : scoreboard bench for mem_stage.
// The driver pushes the expected dmem request and writeback result for each
// directed vector; a monitor pops and compares on every handshake.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    typedef struct packed {
        logic [63:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
        logic        wb_en;
        logic        fault;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_instruction = '0;
    logic [63:0] in_result = '0;
    logic [63:0] in_store_data = '0;
    logic [4:0]  in_rd = '0;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic [63:0] dmem_req_addr;
    logic        dmem_req_write;
    logic [63:0] dmem_req_wdata;
    logic [7:0]  dmem_req_wstrb;
    logic        dmem_resp_valid = 1'b0;
    logic [63:0] dmem_resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_rd;
    logic [63:0] out_data;
    logic        out_wb_en;
    logic        misalign_fault;

    int checks = 0;
    int errors = 0;
    string cur_name = "reset";

    req_t req_q[$];
    out_t out_q[$];

    mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instruction (in_instruction),
        .in_result      (in_result),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_write (dmem_req_write),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_req_wstrb (dmem_req_wstrb),
        .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_data (dmem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rd         (out_rd),
        .out_data       (out_data),
        .out_wb_en      (out_wb_en),
        .misalign_fault (misalign_fault)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic req_t mk_req(input logic [63:0] a, input logic w,
                                    input logic [63:0] d, input logic [7:0] s);
        req_t r;
        r.addr = a; r.write = w; r.wdata = d; r.wstrb = s;
        return r;
    endfunction

    function automatic out_t mk_out(input logic [4:0] rd, input logic [63:0] d,
                                    input logic wb, input logic f);
        out_t o;
        o.rd = rd; o.data = d; o.wb_en = wb; o.fault = f;
        return o;
    endfunction

    task automatic check(input string name, input logic ok, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", cur_name, name, act, exp);
        end
    endtask

    // Monitor: compare every request and writeback handshake against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dmem_req_valid && dmem_req_ready) begin
                req_t act;
                act = mk_req(dmem_req_addr, dmem_req_write, dmem_req_wdata, dmem_req_wstrb);
                checks++;
                if (req_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s/unexpected_req: got %h expected none", cur_name, act);
                end else begin
                    req_t exp;
                    exp = req_q.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL %s/req: got %h expected %h", cur_name, act, exp);
                    end
                end
            end
            if (out_valid && out_ready) begin
                out_t act;
                act = mk_out(out_rd, out_data, out_wb_en, misalign_fault);
                checks++;
                if (out_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s/unexpected_out: got %h expected none", cur_name, act);
                end else begin
                    out_t exp;
                    exp = out_q.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL %s/out: got %h expected %h", cur_name, act, exp);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_timeout", in_ready === 1'b1, 128'(in_ready), 128'd1);
    endtask

    // Hold out_ready low for out_wait cycles (checking stability), then accept.
    task automatic drain_out(input out_t eout, input int out_wait);
        out_t act;
        for (int i = 0; i < out_wait; i++) begin
            tick();
            act = mk_out(out_rd, out_data, out_wb_en, misalign_fault);
            check("out_hold", out_valid === 1'b1 && in_ready === 1'b0 && act === eout,
                  {out_valid, in_ready, 24'd0, 25'(act)}, {1'b1, 1'b0, 24'd0, 25'(eout)});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_txn(input string name, input logic [7:0] code, input logic [63:0] res,
                          input logic [63:0] sd, input logic [4:0] rd, input logic [63:0] resp,
                          input logic is_mem, input req_t ereq, input out_t eout,
                          input int req_wait, input int out_wait);
        req_t act;
        cur_name = name;
        wait_in_ready();
        if (is_mem) req_q.push_back(ereq);
        out_q.push_back(eout);
        in_valid       = 1'b1;
        in_instruction = code;
        in_result      = res;
        in_store_data  = sd;
        in_rd          = rd;
        tick();
        in_valid = 1'b0;
        if (!is_mem) begin
            check("latency", out_valid === 1'b1 && dmem_req_valid === 1'b0,
                  {out_valid, dmem_req_valid}, 128'b10);
        end else begin
            // Hold off the request; a stray response here must be ignored.
            for (int i = 0; i < req_wait; i++) begin
                dmem_resp_valid = 1'b1;
                dmem_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
                tick();
                act = mk_req(dmem_req_addr, dmem_req_write, dmem_req_wdata, dmem_req_wstrb);
                check("req_hold",
                      dmem_req_valid === 1'b1 && in_ready === 1'b0 && out_valid === 1'b0 && act === ereq,
                      {dmem_req_valid, in_ready, out_valid, 125'(act)},
                      {1'b1, 1'b0, 1'b0, 125'(ereq)});
            end
            dmem_resp_valid = 1'b0;
            dmem_req_ready  = 1'b1;
            tick();
            dmem_req_ready = 1'b0;
            tick();
            check("wait_idle", out_valid === 1'b0 && dmem_req_valid === 1'b0,
                  {out_valid, dmem_req_valid}, 128'd0);
            dmem_resp_valid = 1'b1;
            dmem_resp_data  = resp;
            tick();
            dmem_resp_valid = 1'b0;
            dmem_resp_data  = '0;
        end
        drain_out(eout, out_wait);
        check("drained", req_q.size() == 0 && out_q.size() == 0,
              {64'(req_q.size()), 64'(out_q.size())}, 128'd0);
        check("back_idle", in_ready === 1'b1 && out_valid === 1'b0 && misalign_fault === 1'b0,
              {in_ready, out_valid, misalign_fault}, 128'b100);
        req_q.delete();
        out_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("reset_outputs",
              {dmem_req_valid, dmem_req_addr, dmem_req_write, dmem_req_wdata, dmem_req_wstrb,
               out_valid, out_rd, out_data, out_wb_en, misalign_fault} === '0,
              {dmem_req_valid, out_valid, out_wb_en, misalign_fault}, 128'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", in_ready === 1'b1, 128'(in_ready), 128'd1);

        do_txn("add", 8'd0, 64'h1234, 64'd0, 5'd5, 64'd0, 1'b0,
               mk_req(0, 0, 0, 0), mk_out(5'd5, 64'h1234, 1'b1, 1'b0), 0, 0);
        do_txn("pass_rd0", 8'd10, 64'hDEAD, 64'd0, 5'd0, 64'd0, 1'b0,
               mk_req(0, 0, 0, 0), mk_out(5'd0, 64'hDEAD, 1'b0, 1'b0), 0, 1);
        do_txn("lb", 8'd59, 64'h1003, 64'd0, 5'd7, 64'h0000_0000_8000_0000, 1'b1,
               mk_req(64'h1000, 1'b0, 64'd0, 8'h00),
               mk_out(5'd7, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0), 0, 0);
        do_txn("lbu", 8'd62, 64'h1003, 64'd0, 5'd8, 64'h0000_0000_8000_0000, 1'b1,
               mk_req(64'h1000, 1'b0, 64'd0, 8'h00),
               mk_out(5'd8, 64'h80, 1'b1, 1'b0), 0, 0);
        do_txn("sh_stall", 8'd44, 64'h2006, 64'hBEEF, 5'd3, 64'd0, 1'b1,
               mk_req(64'h2000, 1'b1, 64'hBEEF_0000_0000_0000, 8'hC0),
               mk_out(5'd3, 64'd0, 1'b0, 1'b0), 3, 2);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        do_txn("lw_misalign", 8'd61, 64'h1002, 64'd0, 5'd9, 64'h1122_3344_8899_AABB, 1'b0,
               mk_req(0, 0, 0, 0), mk_out(5'd9, 64'd0, 1'b0, 1'b1), 0, 1);
`else
        do_txn("lw_misalign", 8'd61, 64'h1002, 64'd0, 5'd9, 64'h1122_3344_8899_AABB, 1'b1,
               mk_req(64'h1000, 1'b0, 64'd0, 8'h00),
               mk_out(5'd9, 64'hFFFF_FFFF_8899_AABB, 1'b1, 1'b0), 0, 0);
`endif
        do_txn("ld", 8'd65, 64'h3008, 64'd0, 5'd10, 64'h0123_4567_89AB_CDEF, 1'b1,
               mk_req(64'h3008, 1'b0, 64'd0, 8'h00),
               mk_out(5'd10, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0), 1, 0);
        do_txn("lhu", 8'd63, 64'h4006, 64'd0, 5'd11, 64'hF00D_0000_0000_0000, 1'b1,
               mk_req(64'h4000, 1'b0, 64'd0, 8'h00),
               mk_out(5'd11, 64'hF00D, 1'b1, 1'b0), 0, 0);
        do_txn("lh", 8'd60, 64'h4006, 64'd0, 5'd12, 64'hF00D_0000_0000_0000, 1'b1,
               mk_req(64'h4000, 1'b0, 64'd0, 8'h00),
               mk_out(5'd12, 64'hFFFF_FFFF_FFFF_F00D, 1'b1, 1'b0), 0, 0);
        do_txn("sb", 8'd43, 64'h5001, 64'hA5, 5'd0, 64'd0, 1'b1,
               mk_req(64'h5000, 1'b1, 64'hA500, 8'h02),
               mk_out(5'd0, 64'd0, 1'b0, 1'b0), 0, 0);
        do_txn("sd", 8'd46, 64'h6000, 64'h1122_3344_5566_7788, 5'd1, 64'd0, 1'b1,
               mk_req(64'h6000, 1'b1, 64'h1122_3344_5566_7788, 8'hFF),
               mk_out(5'd1, 64'd0, 1'b0, 1'b0), 0, 0);
        do_txn("sw", 8'd45, 64'h7004, 64'hCAFE_BABE, 5'd2, 64'd0, 1'b1,
               mk_req(64'h7000, 1'b1, 64'hCAFE_BABE_0000_0000, 8'hF0),
               mk_out(5'd2, 64'd0, 1'b0, 1'b0), 0, 0);
        do_txn("lwu", 8'd64, 64'h8004, 64'd0, 5'd13, 64'h8765_4321_0000_0000, 1'b1,
               mk_req(64'h8000, 1'b0, 64'd0, 8'h00),
               mk_out(5'd13, 64'h8765_4321, 1'b1, 1'b0), 0, 0);
        do_txn("ld_rd0", 8'd65, 64'h9000, 64'd0, 5'd0, 64'hAA, 1'b1,
               mk_req(64'h9000, 1'b0, 64'd0, 8'h00),
               mk_out(5'd0, 64'hAA, 1'b0, 1'b0), 0, 0);

        // Reset while waiting for the response, then a stray response.
        cur_name = "reset_mid";
        wait_in_ready();
        req_q.push_back(mk_req(64'hA000, 1'b0, 64'd0, 8'h00));
        in_valid = 1'b1; in_instruction = 8'd65; in_result = 64'hA000; in_rd = 5'd4;
        tick();
        in_valid = 1'b0;
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        check("req_sent", req_q.size() == 0, 128'(req_q.size()), 128'd0);
        rst_n = 1'b0;
        #2;
        check("reset_mid_outputs", {dmem_req_valid, out_valid, out_wb_en, misalign_fault} === 4'b0,
              {dmem_req_valid, out_valid, out_wb_en, misalign_fault}, 128'd0);
        tick();
        tick();
        rst_n = 1'b1;
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 64'h5555;
        out_ready = 1'b1;
        tick();
        dmem_resp_valid = 1'b0;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (out_valid !== 1'b0 || dmem_req_valid !== 1'b0) seen = 1'b1;
                tick();
            end
            check("no_out_after_reset", seen == 1'b0, 128'(seen), 128'd0);
        end
        out_ready = 1'b0;
        check("ready_after_mid_reset", in_ready === 1'b1, 128'(in_ready), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
